shared_multiplier_scheduler: RTL and testbench

- Time-shares one pipelined unsigned multiplier among NUM_REQ requesters.
- Each requester presents an operand pair through a valid/ready handshake. A round-robin arbiter admits at most one pair per cycle into a LATENCY-stage multiply pipeline.
- Each product returns on a shared result bus, tagged with its requester's one-hot valid bit.
- It sits between the per-channel math front ends and a single DSP-backed multiplier, replacing one multiplier per channel.

---
 rtl/shared_multiplier_scheduler.sv | 174 +++++++++++++++++
 tb/tb_shared_multiplier_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_multiplier_scheduler.sv
// Round-robin time-sharing of one pipelined unsigned multiplier among NUM_REQ requesters.
// Accept-to-result latency is LATENCY edges; hold freezes the inner stages and drops req_ready, and the output stage loads bubbles.
module shared_multiplier_scheduler #(
    parameter int WIDTH   = 18,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         hold,
    output logic [2*WIDTH-1:0]           result,
    output logic [NUM_REQ-1:0]           result_valid,
    output logic [$clog2(LATENCY+1)-1:0] in_flight,
    output logic [31:0]                  op_count
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               accept;

    logic               out_load;
    logic [NUM_REQ-1:0] out_own_nxt;
    logic [2*WIDTH-1:0] out_dat_nxt;

    // Search starts at ptr and wraps, so the first valid requester after the last winner is granted.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = ptr;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            cand = sum[PW-1:0];
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && gnt_idx == PW'(i)) begin
                gnt_oh[i] = 1'b1;
                sel_a     = req_a[i*WIDTH +: WIDTH];
                sel_b     = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (reset && !hold) ? gnt_oh : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    generate
        if (LATENCY == 1) begin : g_single
            assign out_load    = accept;
            assign out_own_nxt = req_ready;
            assign out_dat_nxt = {{WIDTH{1'b0}}, sel_a} * {{WIDTH{1'b0}}, sel_b};
        end else begin : g_pipe
            logic               s1_vld;
            logic [NUM_REQ-1:0] s1_own;
            logic [WIDTH-1:0]   s1_a;
            logic [WIDTH-1:0]   s1_b;
            logic [2*WIDTH-1:0] s1_prod;
            logic               tail_vld;
            logic [NUM_REQ-1:0] tail_own;
            logic [2*WIDTH-1:0] tail_dat;

            assign s1_prod = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s1_vld <= 1'b0;
                    s1_own <= '0;
                    s1_a   <= '0;
                    s1_b   <= '0;
                end else if (!hold) begin
                    s1_vld <= accept;
                    s1_own <= req_ready;
                    if (accept) begin
                        s1_a <= sel_a;
                        s1_b <= sel_b;
                    end
                end
            end

            if (LATENCY == 2) begin : g_direct
                assign tail_vld = s1_vld;
                assign tail_own = s1_own;
                assign tail_dat = s1_prod;
            end else begin : g_mid
                // Plain register chain after the multiply, left for retiming into the DSP.
                localparam int M = LATENCY - 2;
                logic               m_vld [M];
                logic [NUM_REQ-1:0] m_own [M];
                logic [2*WIDTH-1:0] m_dat [M];

                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        for (int k = 0; k < M; k++) begin
                            m_vld[k] <= 1'b0;
                            m_own[k] <= '0;
                            m_dat[k] <= '0;
                        end
                    end else if (!hold) begin
                        m_vld[0] <= s1_vld;
                        m_own[0] <= s1_own;
                        m_dat[0] <= s1_prod;
                        for (int k = 1; k < M; k++) begin
                            m_vld[k] <= m_vld[k-1];
                            m_own[k] <= m_own[k-1];
                            m_dat[k] <= m_dat[k-1];
                        end
                    end
                end

                assign tail_vld = m_vld[M-1];
                assign tail_own = m_own[M-1];
                assign tail_dat = m_dat[M-1];
            end

            assign out_load    = !hold && tail_vld;
            assign out_own_nxt = tail_own;
            assign out_dat_nxt = tail_dat;
        end
    endgenerate

    // Output stage takes a bubble while held, so each product is shown for exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result       <= '0;
            result_valid <= '0;
            in_flight    <= '0;
            op_count     <= '0;
        end else begin
            result_valid <= out_load ? out_own_nxt : '0;
            if (out_load) begin
                result   <= out_dat_nxt;
                op_count <= op_count + 32'd1;
            end
            if (accept && !out_load) begin
                in_flight <= in_flight + 1'b1;
            end else if (!accept && out_load) begin
                in_flight <= in_flight - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shared_multiplier_scheduler.sv
// Scoreboard bench: driver predicts grants and products, monitor matches every presented result.
module tb_shared_multiplier_scheduler;
    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           hold = 1'b0;
    logic [2*W-1:0] result;
    logic [N-1:0]   result_valid;
    logic [1:0]     in_flight;
    logic [31:0]    op_count;

    shared_multiplier_scheduler #(.WIDTH(W), .NUM_REQ(N), .LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .hold(hold), .result(result), .result_valid(result_valid),
        .in_flight(in_flight), .op_count(op_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]   own;
        logic [2*W-1:0] prod;
        int             rem;   // non-held edges still needed before presentation
    } exp_t;

    exp_t           exp_q[$];
    int             errors = 0;
    int             checks = 0;
    int             m_ptr = 0;
    int             n_acc = 0;
    int             n_pres = 0;
    logic [2*W-1:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic h, output int g);
        logic [N-1:0] exp_rdy;
        exp_t         e;
        int           pa;
        int           pb;
        @(negedge clock);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        hold      = h;
        #1;
        g       = -1;
        exp_rdy = '0;
        if (reset && !h) begin
            g = rr_pick(v, m_ptr);
            if (g >= 0) exp_rdy = N'(1) << g;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            pa     = int'(a[g*W +: W]);
            pb     = int'(b[g*W +: W]);
            e.own  = exp_rdy;
            e.prod = (2*W)'(pa * pb);
            e.rem  = L;
            exp_q.push_back(e);
            m_ptr = (g + 1) % N;
            n_acc++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " result"}, 32'(result), 32'd0);
        check({tag, " result_valid"}, 32'(result_valid), 32'd0);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " in_flight"}, 32'(in_flight), 32'd0);
        check({tag, " op_count"}, op_count, 32'd0);
    endtask

    // Monitor: ages the expected entries on each unheld edge and matches whatever the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            if (reset && !hold) begin
                for (int i = 0; i < exp_q.size(); i++) exp_q[i].rem = exp_q[i].rem - 1;
            end
            #2;
            if (exp_q.size() > 0 && exp_q[0].rem <= 0) begin
                e = exp_q.pop_front();
                n_pres++;
                last_res = e.prod;
                check("result_valid owner", 32'(result_valid), 32'(e.own));
                check("result product", 32'(result), 32'(e.prod));
            end else begin
                check("result_valid idle", 32'(result_valid), 32'd0);
                check("result held", 32'(result), 32'(last_res));
            end
            check("op_count", op_count, 32'(n_pres));
            check("in_flight", 32'(in_flight), 32'(n_acc - n_pres));
        end
    end

    initial begin
        int             g;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   cur_v;
        logic [N*W-1:0] cur_a;
        logic [N*W-1:0] cur_b;

        // Power-up reset with requests pending: req_ready must stay low.
        #2;
        reset     = 1'b0;
        req_valid = '1;
        #1;
        check_reset_outputs("por");
        @(posedge clock);
        #1;
        check_reset_outputs("por held");
        req_valid = '0;
        #2;
        reset = 1'b1;

        // Single request from requester 2.
        a = '0; b = '0;
        a[2*W +: W] = 8'd7; b[2*W +: W] = 8'd9;
        step(4'b0100, a, b, 1'b0, g);
        repeat (4) step('0, a, b, 1'b0, g);

        // Full contention: A=i+1, B=10.
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = W'(i + 1);
            b[i*W +: W] = 8'd10;
        end
        repeat (8) step('1, a, b, 1'b0, g);
        repeat (3) step('0, a, b, 1'b0, g);

        // Maximum operands.
        a[0 +: W] = 8'hFF; b[0 +: W] = 8'hFF;
        step(4'b0001, a, b, 1'b0, g);
        repeat (3) step('0, a, b, 1'b0, g);

        // Hold mid-stream.
        repeat (3) step('1, a, b, 1'b0, g);
        repeat (2) step('1, a, b, 1'b1, g);
        repeat (5) step('0, a, b, 1'b0, g);

        // Asynchronous reset between edges with operations in flight.
        repeat (2) step('1, a, b, 1'b0, g);
        @(posedge clock);
        #3;
        req_valid = '1;
        reset     = 1'b0;
        #1;
        exp_q.delete();
        m_ptr = 0; n_acc = 0; n_pres = 0; last_res = '0;
        check_reset_outputs("mid reset");
        @(posedge clock);
        #3;
        req_valid = '0;
        reset     = 1'b1;
        step('1, a, b, 1'b0, g);
        repeat (4) step('0, a, b, 1'b0, g);

        // Withdrawal and pointer wrap: ptr now 1, grant 2 then 3, requester 1 withdraws.
        step(4'b0100, a, b, 1'b0, g);
        step(4'b1010, a, b, 1'b0, g);
        step(4'b0000, a, b, 1'b0, g);
        step(4'b0011, a, b, 1'b0, g);
        repeat (4) step('0, a, b, 1'b0, g);

        // Randomised traffic; requesters keep valid and operands stable until accepted or withdrawn.
        cur_v = '0; cur_a = '0; cur_b = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur_v[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        cur_v[i] = 1'b1;
                        cur_a[i*W +: W] = W'($urandom);
                        cur_b[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    cur_v[i] = 1'b0;
                end
            end
            step(cur_v, cur_a, cur_b, ($urandom_range(0, 6) == 0), g);
            if (g >= 0) cur_v[g] = 1'b0;
        end
        repeat (6) step('0, cur_a, cur_b, 1'b0, g);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
